// File: rtl/read_addr_arbiter_pkg.sv
// Shared AXI read-address constants for the AR arbiter: ID widths, slave address map,
// one-hot master tags and the address decoder used to pick a slave.
package read_addr_arbiter_pkg;

    localparam int AXI_ID_BITS  = 4;
    localparam int AXI_IDS_BITS = AXI_ID_BITS + 4;
    localparam int NUM_M        = 3;
    localparam int NUM_S        = 6;
    localparam int NUM_SEL      = NUM_S + 1;
    localparam int SD_IDX       = NUM_S;

    localparam logic [31:0] S0_BASE  = 32'h0000_0000;
    localparam logic [31:0] S0_LIMIT = 32'h0000_3FFF;
    localparam logic [31:0] S1_BASE  = 32'h0001_0000;
    localparam logic [31:0] S1_LIMIT = 32'h0001_FFFF;
    localparam logic [31:0] S2_BASE  = 32'h0002_0000;
    localparam logic [31:0] S2_LIMIT = 32'h0002_FFFF;
    localparam logic [31:0] S3_BASE  = 32'h1002_0000;
    localparam logic [31:0] S3_LIMIT = 32'h1002_03FF;
    localparam logic [31:0] S4_BASE  = 32'h1001_0000;
    localparam logic [31:0] S4_LIMIT = 32'h1001_03FF;
    localparam logic [31:0] S5_BASE  = 32'h2000_0000;
    localparam logic [31:0] S5_LIMIT = 32'h201F_FFFF;

    localparam logic [3:0] TAG_M0 = 4'b0001;
    localparam logic [3:0] TAG_M1 = 4'b0010;
    localparam logic [3:0] TAG_M2 = 4'b0100;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [NUM_SEL-1:0] sel_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0] id;
        logic [31:0]            addr;
        logic [3:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
    } ar_req_t;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    // One-hot slave select; bit SD_IDX is the internal DECERR slave.
    function automatic sel_t decode_addr(input logic [31:0] addr);
        sel_t sel;
        sel = '0;
        if (in_range(addr, S0_BASE, S0_LIMIT))      sel[0] = 1'b1;
        else if (in_range(addr, S1_BASE, S1_LIMIT)) sel[1] = 1'b1;
        else if (in_range(addr, S2_BASE, S2_LIMIT)) sel[2] = 1'b1;
        else if (in_range(addr, S3_BASE, S3_LIMIT)) sel[3] = 1'b1;
        else if (in_range(addr, S4_BASE, S4_LIMIT)) sel[4] = 1'b1;
        else if (in_range(addr, S5_BASE, S5_LIMIT)) sel[5] = 1'b1;
        else                                        sel[SD_IDX] = 1'b1;
        return sel;
    endfunction

    function automatic logic [3:0] master_tag(input logic [1:0] m);
        case (m)
            2'd1:    return TAG_M1;
            2'd2:    return TAG_M2;
            default: return TAG_M0;
        endcase
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

endpackage

// File: rtl/read_addr_arbiter_default_slave.sv
// DECERR responder for unmapped reads: accepts one AR at a time and returns
// ARLEN+1 zero-data beats with RRESP=DECERR, RLAST on the final beat.
module read_addr_arbiter_default_slave
    import read_addr_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_ar_valid,
    input  logic [AXI_IDS_BITS-1:0] i_ar_id,
    input  logic [3:0]              i_ar_len,
    output logic                    o_ar_ready,
    output logic [AXI_IDS_BITS-1:0] o_rid,
    output logic [31:0]             o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    typedef enum logic {DS_IDLE, DS_BURST} ds_state_t;

    ds_state_t               r_state;
    logic [AXI_IDS_BITS-1:0] r_id;
    logic [3:0]              r_len;
    logic [3:0]              r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DS_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                DS_IDLE: begin
                    if (i_ar_valid) begin
                        r_id    <= i_ar_id;
                        r_len   <= i_ar_len;
                        r_cnt   <= '0;
                        r_state <= DS_BURST;
                    end
                end
                DS_BURST: begin
                    if (i_rready) begin
                        if (r_cnt == r_len) begin
                            r_id    <= '0;
                            r_state <= DS_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= DS_IDLE;
            endcase
        end
    end

    assign o_ar_ready = (r_state == DS_IDLE);
    assign o_rvalid   = (r_state == DS_BURST);
    assign o_rlast    = o_rvalid && (r_cnt == r_len);
    assign o_rid      = o_rvalid ? r_id : '0;
    assign o_rresp    = o_rvalid ? RESP_DECERR : 2'b00;
    assign o_rdata    = '0;

endmodule

// File: rtl/read_addr_arbiter.sv
// AR channel arbiter/router: round-robin over three masters, one outstanding burst
// per master, address decode to six slaves plus an internal DECERR slave.
module read_addr_arbiter
    import read_addr_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_BITS-1:0]  ARID_M0,
    input  logic [31:0]             ARADDR_M0,
    input  logic [3:0]              ARLEN_M0,
    input  logic [2:0]              ARSIZE_M0,
    input  logic [1:0]              ARBURST_M0,
    input  logic                    ARVALID_M0,
    output logic                    ARREADY_M0,
    input  logic                    RVALID_M0,
    input  logic                    RREADY_M0,
    input  logic                    RLAST_M0,
    input  logic [AXI_ID_BITS-1:0]  ARID_M1,
    input  logic [31:0]             ARADDR_M1,
    input  logic [3:0]              ARLEN_M1,
    input  logic [2:0]              ARSIZE_M1,
    input  logic [1:0]              ARBURST_M1,
    input  logic                    ARVALID_M1,
    output logic                    ARREADY_M1,
    input  logic                    RVALID_M1,
    input  logic                    RREADY_M1,
    input  logic                    RLAST_M1,
    input  logic [AXI_ID_BITS-1:0]  ARID_M2,
    input  logic [31:0]             ARADDR_M2,
    input  logic [3:0]              ARLEN_M2,
    input  logic [2:0]              ARSIZE_M2,
    input  logic [1:0]              ARBURST_M2,
    input  logic                    ARVALID_M2,
    output logic                    ARREADY_M2,
    input  logic                    RVALID_M2,
    input  logic                    RREADY_M2,
    input  logic                    RLAST_M2,
    output logic [AXI_IDS_BITS-1:0] ARID_S0,
    output logic [31:0]             ARADDR_S0,
    output logic [3:0]              ARLEN_S0,
    output logic [2:0]              ARSIZE_S0,
    output logic [1:0]              ARBURST_S0,
    output logic                    ARVALID_S0,
    input  logic                    ARREADY_S0,
    output logic [AXI_IDS_BITS-1:0] ARID_S1,
    output logic [31:0]             ARADDR_S1,
    output logic [3:0]              ARLEN_S1,
    output logic [2:0]              ARSIZE_S1,
    output logic [1:0]              ARBURST_S1,
    output logic                    ARVALID_S1,
    input  logic                    ARREADY_S1,
    output logic [AXI_IDS_BITS-1:0] ARID_S2,
    output logic [31:0]             ARADDR_S2,
    output logic [3:0]              ARLEN_S2,
    output logic [2:0]              ARSIZE_S2,
    output logic [1:0]              ARBURST_S2,
    output logic                    ARVALID_S2,
    input  logic                    ARREADY_S2,
    output logic [AXI_IDS_BITS-1:0] ARID_S3,
    output logic [31:0]             ARADDR_S3,
    output logic [3:0]              ARLEN_S3,
    output logic [2:0]              ARSIZE_S3,
    output logic [1:0]              ARBURST_S3,
    output logic                    ARVALID_S3,
    input  logic                    ARREADY_S3,
    output logic [AXI_IDS_BITS-1:0] ARID_S4,
    output logic [31:0]             ARADDR_S4,
    output logic [3:0]              ARLEN_S4,
    output logic [2:0]              ARSIZE_S4,
    output logic [1:0]              ARBURST_S4,
    output logic                    ARVALID_S4,
    input  logic                    ARREADY_S4,
    output logic [AXI_IDS_BITS-1:0] ARID_S5,
    output logic [31:0]             ARADDR_S5,
    output logic [3:0]              ARLEN_S5,
    output logic [2:0]              ARSIZE_S5,
    output logic [1:0]              ARBURST_S5,
    output logic                    ARVALID_S5,
    input  logic                    ARREADY_S5,
    output logic [AXI_IDS_BITS-1:0] RID_SD,
    output logic [31:0]             RDATA_SD,
    output logic [1:0]              RRESP_SD,
    output logic                    RLAST_SD,
    output logic                    RVALID_SD,
    input  logic                    RREADY_SD
);

    typedef enum logic {ST_IDLE, ST_ADDR} arb_state_t;

    arb_state_t       r_state;
    logic [1:0]       r_win;
    sel_t             r_sel;
    logic [1:0]       r_rr_ptr;
    logic [NUM_M-1:0] r_outstanding;

    // Entry 3 is a permanently idle pad so 2-bit indices never leave the array.
    ar_req_t          w_m_req [4];
    logic [3:0]       w_m_valid;
    logic [3:0]       w_elig;
    logic [NUM_M-1:0] w_retire;
    logic [NUM_M-1:0] w_set;
    logic [NUM_S-1:0] w_s_ready;
    logic [NUM_S-1:0] w_route;
    logic             w_active;
    ar_req_t          w_win;
    logic             w_win_valid;
    logic [AXI_IDS_BITS-1:0] w_tag_id;
    logic             w_sd_valid;
    logic             w_sd_ready;
    logic             w_grant_ready;
    logic             w_hs;
    logic             w_any_elig;
    logic [1:0]       w_pick;
    logic [1:0]       w_cand;

    assign w_m_req[0] = '{id: ARID_M0, addr: ARADDR_M0, len: ARLEN_M0, size: ARSIZE_M0, burst: ARBURST_M0};
    assign w_m_req[1] = '{id: ARID_M1, addr: ARADDR_M1, len: ARLEN_M1, size: ARSIZE_M1, burst: ARBURST_M1};
    assign w_m_req[2] = '{id: ARID_M2, addr: ARADDR_M2, len: ARLEN_M2, size: ARSIZE_M2, burst: ARBURST_M2};
    assign w_m_req[3] = '0;
    assign w_m_valid  = {1'b0, ARVALID_M2, ARVALID_M1, ARVALID_M0};
    assign w_elig     = {1'b0, w_m_valid[NUM_M-1:0] & ~r_outstanding};
    assign w_retire   = {RVALID_M2 & RREADY_M2 & RLAST_M2,
                         RVALID_M1 & RREADY_M1 & RLAST_M1,
                         RVALID_M0 & RREADY_M0 & RLAST_M0};
    assign w_s_ready  = {ARREADY_S5, ARREADY_S4, ARREADY_S3, ARREADY_S2, ARREADY_S1, ARREADY_S0};

    // Round-robin search: first eligible master at or after r_rr_ptr (mod 3).
    // NOTE: every always_comb output gets a default up front so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_any_elig = 1'b0;
        w_pick     = r_rr_ptr;
        w_cand     = r_rr_ptr;
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_any_elig && w_elig[w_cand]) begin
                w_any_elig = 1'b1;
                w_pick     = w_cand;
            end
            w_cand = rr_next(w_cand);
        end
    end

    assign w_active      = (r_state == ST_ADDR);
    assign w_win         = w_m_req[r_win];
    assign w_win_valid   = w_m_valid[r_win];
    assign w_tag_id      = {master_tag(r_win), w_win.id};
    assign w_route       = w_active ? r_sel[NUM_S-1:0] : '0;
    assign w_sd_valid    = w_active && r_sel[SD_IDX] && w_win_valid;
    assign w_grant_ready = w_active && ((|(r_sel[NUM_S-1:0] & w_s_ready)) || (r_sel[SD_IDX] && w_sd_ready));
    assign w_hs          = w_grant_ready && w_win_valid;
    assign w_set         = w_hs ? (3'b001 << r_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_win         <= '0;
            r_sel         <= '0;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_retire) | w_set;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_win   <= w_pick;
                        r_sel   <= decode_addr(w_m_req[w_pick].addr);
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_hs) begin
                        r_rr_ptr <= rr_next(r_win);
                        r_sel    <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ARREADY_M0 = w_grant_ready && (r_win == 2'd0);
    assign ARREADY_M1 = w_grant_ready && (r_win == 2'd1);
    assign ARREADY_M2 = w_grant_ready && (r_win == 2'd2);

    assign ARVALID_S0 = w_route[0] && w_win_valid;
    assign ARVALID_S1 = w_route[1] && w_win_valid;
    assign ARVALID_S2 = w_route[2] && w_win_valid;
    assign ARVALID_S3 = w_route[3] && w_win_valid;
    assign ARVALID_S4 = w_route[4] && w_win_valid;
    assign ARVALID_S5 = w_route[5] && w_win_valid;

    assign ARID_S0 = w_route[0] ? w_tag_id : '0;
    assign ARID_S1 = w_route[1] ? w_tag_id : '0;
    assign ARID_S2 = w_route[2] ? w_tag_id : '0;
    assign ARID_S3 = w_route[3] ? w_tag_id : '0;
    assign ARID_S4 = w_route[4] ? w_tag_id : '0;
    assign ARID_S5 = w_route[5] ? w_tag_id : '0;

    assign ARADDR_S0 = w_route[0] ? w_win.addr : '0;
    assign ARADDR_S1 = w_route[1] ? w_win.addr : '0;
    assign ARADDR_S2 = w_route[2] ? w_win.addr : '0;
    assign ARADDR_S3 = w_route[3] ? w_win.addr : '0;
    assign ARADDR_S4 = w_route[4] ? w_win.addr : '0;
    assign ARADDR_S5 = w_route[5] ? w_win.addr : '0;

    assign ARLEN_S0 = w_route[0] ? w_win.len : '0;
    assign ARLEN_S1 = w_route[1] ? w_win.len : '0;
    assign ARLEN_S2 = w_route[2] ? w_win.len : '0;
    assign ARLEN_S3 = w_route[3] ? w_win.len : '0;
    assign ARLEN_S4 = w_route[4] ? w_win.len : '0;
    assign ARLEN_S5 = w_route[5] ? w_win.len : '0;

    assign ARSIZE_S0 = w_route[0] ? w_win.size : '0;
    assign ARSIZE_S1 = w_route[1] ? w_win.size : '0;
    assign ARSIZE_S2 = w_route[2] ? w_win.size : '0;
    assign ARSIZE_S3 = w_route[3] ? w_win.size : '0;
    assign ARSIZE_S4 = w_route[4] ? w_win.size : '0;
    assign ARSIZE_S5 = w_route[5] ? w_win.size : '0;

    assign ARBURST_S0 = w_route[0] ? w_win.burst : '0;
    assign ARBURST_S1 = w_route[1] ? w_win.burst : '0;
    assign ARBURST_S2 = w_route[2] ? w_win.burst : '0;
    assign ARBURST_S3 = w_route[3] ? w_win.burst : '0;
    assign ARBURST_S4 = w_route[4] ? w_win.burst : '0;
    assign ARBURST_S5 = w_route[5] ? w_win.burst : '0;

    read_addr_arbiter_default_slave u_default_slave (
        .clk        (clk),
        .rst        (rst),
        .i_ar_valid (w_sd_valid),
        .i_ar_id    (w_tag_id),
        .i_ar_len   (w_win.len),
        .o_ar_ready (w_sd_ready),
        .o_rid      (RID_SD),
        .o_rdata    (RDATA_SD),
        .o_rresp    (RRESP_SD),
        .o_rlast    (RLAST_SD),
        .o_rvalid   (RVALID_SD),
        .i_rready   (RREADY_SD)
    );

endmodule

// File: tb/tb_read_addr_arbiter.sv
// Directed bench for read_addr_arbiter: grant latency, round-robin order, outstanding
// blocking, DECERR bursts with back-pressure and reset while a grant is pending.
module tb_read_addr_arbiter;
    import read_addr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic [2:0][3:0]  arid_m;
    logic [2:0][31:0] araddr_m;
    logic [2:0][3:0]  arlen_m;
    logic [2:0][2:0]  arsize_m;
    logic [2:0][1:0]  arburst_m;
    logic [2:0]       arvalid_m, arready_m, rvalid_m, rready_m, rlast_m;

    logic [5:0][7:0]  arid_s;
    logic [5:0][31:0] araddr_s;
    logic [5:0][3:0]  arlen_s;
    logic [5:0][2:0]  arsize_s;
    logic [5:0][1:0]  arburst_s;
    logic [5:0]       arvalid_s, arready_s;

    logic [7:0]  rid_sd;
    logic [31:0] rdata_sd;
    logic [1:0]  rresp_sd;
    logic        rlast_sd, rvalid_sd, rready_sd;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    read_addr_arbiter dut (
        .clk(clk), .rst(rst),
        .ARID_M0(arid_m[0]), .ARADDR_M0(araddr_m[0]), .ARLEN_M0(arlen_m[0]), .ARSIZE_M0(arsize_m[0]),
        .ARBURST_M0(arburst_m[0]), .ARVALID_M0(arvalid_m[0]), .ARREADY_M0(arready_m[0]),
        .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]), .RLAST_M0(rlast_m[0]),
        .ARID_M1(arid_m[1]), .ARADDR_M1(araddr_m[1]), .ARLEN_M1(arlen_m[1]), .ARSIZE_M1(arsize_m[1]),
        .ARBURST_M1(arburst_m[1]), .ARVALID_M1(arvalid_m[1]), .ARREADY_M1(arready_m[1]),
        .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]), .RLAST_M1(rlast_m[1]),
        .ARID_M2(arid_m[2]), .ARADDR_M2(araddr_m[2]), .ARLEN_M2(arlen_m[2]), .ARSIZE_M2(arsize_m[2]),
        .ARBURST_M2(arburst_m[2]), .ARVALID_M2(arvalid_m[2]), .ARREADY_M2(arready_m[2]),
        .RVALID_M2(rvalid_m[2]), .RREADY_M2(rready_m[2]), .RLAST_M2(rlast_m[2]),
        .ARID_S0(arid_s[0]), .ARADDR_S0(araddr_s[0]), .ARLEN_S0(arlen_s[0]), .ARSIZE_S0(arsize_s[0]),
        .ARBURST_S0(arburst_s[0]), .ARVALID_S0(arvalid_s[0]), .ARREADY_S0(arready_s[0]),
        .ARID_S1(arid_s[1]), .ARADDR_S1(araddr_s[1]), .ARLEN_S1(arlen_s[1]), .ARSIZE_S1(arsize_s[1]),
        .ARBURST_S1(arburst_s[1]), .ARVALID_S1(arvalid_s[1]), .ARREADY_S1(arready_s[1]),
        .ARID_S2(arid_s[2]), .ARADDR_S2(araddr_s[2]), .ARLEN_S2(arlen_s[2]), .ARSIZE_S2(arsize_s[2]),
        .ARBURST_S2(arburst_s[2]), .ARVALID_S2(arvalid_s[2]), .ARREADY_S2(arready_s[2]),
        .ARID_S3(arid_s[3]), .ARADDR_S3(araddr_s[3]), .ARLEN_S3(arlen_s[3]), .ARSIZE_S3(arsize_s[3]),
        .ARBURST_S3(arburst_s[3]), .ARVALID_S3(arvalid_s[3]), .ARREADY_S3(arready_s[3]),
        .ARID_S4(arid_s[4]), .ARADDR_S4(araddr_s[4]), .ARLEN_S4(arlen_s[4]), .ARSIZE_S4(arsize_s[4]),
        .ARBURST_S4(arburst_s[4]), .ARVALID_S4(arvalid_s[4]), .ARREADY_S4(arready_s[4]),
        .ARID_S5(arid_s[5]), .ARADDR_S5(araddr_s[5]), .ARLEN_S5(arlen_s[5]), .ARSIZE_S5(arsize_s[5]),
        .ARBURST_S5(arburst_s[5]), .ARVALID_S5(arvalid_s[5]), .ARREADY_S5(arready_s[5]),
        .RID_SD(rid_sd), .RDATA_SD(rdata_sd), .RRESP_SD(rresp_sd), .RLAST_SD(rlast_sd),
        .RVALID_SD(rvalid_sd), .RREADY_SD(rready_sd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len);
        arid_m[m]    = id;
        araddr_m[m]  = addr;
        arlen_m[m]   = len;
        arsize_m[m]  = 3'd2;
        arburst_m[m] = 2'b01;
        arvalid_m[m] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
        arvalid_m = '0; rvalid_m = '0; rready_m = '0; rlast_m = '0;
        arready_s = 6'b111111;
        rready_sd = 1'b0;

        // Reset state
        tick(); tick(); #1;
        check("rst_arvalid_s", 32'(arvalid_s), 32'h0);
        check("rst_arready_m", 32'(arready_m), 32'h0);
        check("rst_sd_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h0);
        check("rst_araddr_s1", araddr_s[1], 32'h0);
        check("rst_outstanding", 32'(dut.r_outstanding), 32'h0);

        // M1 -> S1, ARLEN=3: routed the cycle after ARVALID rises
        rst = 1'b0;
        request(1, 4'h5, 32'h0001_0040, 4'd3);
        tick(); #1;
        check("m1_arvalid_s", 32'(arvalid_s), 32'h02);
        check("m1_arid_s1", 32'(arid_s[1]), 32'h25);
        check("m1_araddr_s1", araddr_s[1], 32'h0001_0040);
        check("m1_arlen_s1", 32'(arlen_s[1]), 32'h3);
        check("m1_size_burst_s1", 32'({arsize_s[1], arburst_s[1]}), 32'h09);
        check("m1_arready_m", 32'(arready_m), 32'h2);
        check("m1_araddr_s0_idle", araddr_s[0], 32'h0);
        tick(); arvalid_m[1] = 1'b0; #1;
        check("m1_post_arvalid_s", 32'(arvalid_s), 32'h0);
        check("m1_post_arready_m", 32'(arready_m), 32'h0);
        check("m1_outstanding", 32'(dut.r_outstanding), 32'h2);
        rvalid_m[1] = 1'b1; rready_m[1] = 1'b1; rlast_m[1] = 1'b1;
        tick(); rvalid_m = '0; rready_m = '0; rlast_m = '0; #1;
        check("m1_retired", 32'(dut.r_outstanding), 32'h0);

        // Three simultaneous requests after reset: M0, M1, M2 two cycles apart
        rst = 1'b1;
        tick(); rst = 1'b0;
        request(0, 4'h1, 32'h0000_0100, 4'd0);
        request(1, 4'h2, 32'h0002_0000, 4'd1);
        request(2, 4'h3, 32'h2000_0000, 4'd7);
        tick(); #1;
        check("rr_g0_arvalid_s", 32'(arvalid_s), 32'h01);
        check("rr_g0_arready_m", 32'(arready_m), 32'h1);
        check("rr_g0_arid_s0", 32'(arid_s[0]), 32'h11);
        tick(); arvalid_m[0] = 1'b0; #1;
        check("rr_gap_arvalid_s", 32'(arvalid_s), 32'h0);
        tick(); #1;
        check("rr_g1_arvalid_s", 32'(arvalid_s), 32'h04);
        check("rr_g1_arready_m", 32'(arready_m), 32'h2);
        check("rr_g1_araddr_s2", araddr_s[2], 32'h0002_0000);
        tick(); arvalid_m[1] = 1'b0; #1;
        tick(); #1;
        check("rr_g2_arvalid_s", 32'(arvalid_s), 32'h20);
        check("rr_g2_arready_m", 32'(arready_m), 32'h4);
        check("rr_g2_arid_s5", 32'(arid_s[5]), 32'h43);
        check("rr_g2_arlen_s5", 32'(arlen_s[5]), 32'h7);
        tick(); arvalid_m[2] = 1'b0; #1;
        check("rr_outstanding", 32'(dut.r_outstanding), 32'h7);

        // M0 re-requests with a burst outstanding: blocked until RLAST handshake
        request(0, 4'h6, 32'h0001_0000, 4'd0);
        tick(); #1;
        check("blk_c1_arvalid_s", 32'(arvalid_s), 32'h0);
        check("blk_c1_arready_m", 32'(arready_m), 32'h0);
        tick(); #1;
        check("blk_c2_arvalid_s", 32'(arvalid_s), 32'h0);
        rvalid_m[0] = 1'b1; rready_m[0] = 1'b1; rlast_m[0] = 1'b1;
        tick(); rvalid_m = '0; rready_m = '0; rlast_m = '0; #1;
        check("blk_cleared_arvalid_s", 32'(arvalid_s), 32'h0);
        check("blk_cleared_outstanding", 32'(dut.r_outstanding), 32'h6);
        tick(); #1;
        check("blk_grant_arvalid_s", 32'(arvalid_s), 32'h02);
        check("blk_grant_arready_m", 32'(arready_m), 32'h1);
        check("blk_grant_arid_s1", 32'(arid_s[1]), 32'h16);
        tick(); arvalid_m[0] = 1'b0; #1;
        check("blk_outstanding", 32'(dut.r_outstanding), 32'h7);

        // M2 unmapped read, ARLEN=1: two DECERR beats with back-pressure
        rvalid_m[1] = 1'b1; rready_m[1] = 1'b1; rlast_m[1] = 1'b1;
        rvalid_m[2] = 1'b1; rready_m[2] = 1'b1; rlast_m[2] = 1'b1;
        tick(); rvalid_m = '0; rready_m = '0; rlast_m = '0;
        request(2, 4'hA, 32'h3000_0000, 4'd1);
        tick(); #1;
        check("sd_grant_arvalid_s", 32'(arvalid_s), 32'h0);
        check("sd_grant_arready_m", 32'(arready_m), 32'h4);
        check("sd_grant_rvalid", 32'(rvalid_sd), 32'h0);
        tick(); arvalid_m[2] = 1'b0; #1;
        check("sd_b0_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h2);
        check("sd_b0_rid", 32'(rid_sd), 32'h4A);
        check("sd_b0_rresp", 32'(rresp_sd), 32'h3);
        check("sd_b0_rdata", rdata_sd, 32'h0);
        tick(); #1;
        check("sd_b0_stall_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h2);
        rready_sd = 1'b1;
        tick(); rready_sd = 1'b0; #1;
        check("sd_b1_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h3);
        check("sd_b1_rid", 32'(rid_sd), 32'h4A);
        tick(); #1;
        check("sd_b1_stall_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h3);
        rready_sd = 1'b1;
        tick(); rready_sd = 1'b0; #1;
        check("sd_done_valid_last", 32'({rvalid_sd, rlast_sd}), 32'h0);
        check("sd_done_rid", 32'(rid_sd), 32'h0);

        // Reset while M1 waits in ADDR on a stalled S5
        arready_s[5] = 1'b0;
        request(1, 4'h7, 32'h2000_0040, 4'd2);
        tick(); #1;
        check("rst_addr_arvalid_s", 32'(arvalid_s), 32'h20);
        check("rst_addr_arready_m", 32'(arready_m), 32'h0);
        tick(); #1;
        check("rst_hold_araddr_s5", araddr_s[5], 32'h2000_0040);
        rst = 1'b1;
        tick(); #1;
        check("rst_mid_arvalid_s", 32'(arvalid_s), 32'h0);
        check("rst_mid_arready_m", 32'(arready_m), 32'h0);
        check("rst_mid_araddr_s5", araddr_s[5], 32'h0);
        check("rst_mid_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
        check("rst_mid_outstanding", 32'(dut.r_outstanding), 32'h0);

        rst = 1'b0;
        arvalid_m = '0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
